// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// Scans four snapshotted hex digits onto a common-anode 7-segment display,
// with a blanking gap per slot. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter int SHOW_CYC  = 49152,
  parameter int BLANK_CYC = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_start
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam bit          HAS_BLANK  = (BLANK_CYC > 0);
  localparam logic [15:0] SHOW_LOAD  = 16'(SHOW_CYC - 1);
  localparam logic [15:0] BLANK_LOAD = 16'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] snap, snap_nxt;
  logic [3:0]  dp_snap, dp_nxt;
  logic [1:0]  idx_nxt;
  logic [7:0]  seg_nxt;
  logic [3:0]  an_nxt;
  logic        fs_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h18;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h27;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] glyph(input logic [15:0] sn, input logic [1:0] i);
    logic [3:0] d;
    d = sn[{i, 2'b00} +: 4];
    glyph = decode(d);
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    case (i)
      2'd3: if (sn[15:12] == 4'h0) glyph = 7'h7F;
      2'd2: if (sn[15:8] == 8'h00) glyph = 7'h7F;
      2'd1: if (sn[15:4] == 12'h000) glyph = 7'h7F;
      default: ;
    endcase
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    dp_nxt    = dp_snap;
    idx_nxt   = digit_idx;
    fs_nxt    = 1'b0;
    seg_nxt   = 8'hFF;
    an_nxt    = 4'hF;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      cnt_nxt   = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          snap_nxt  = digits;
          dp_nxt    = dp_mask;
          idx_nxt   = 2'd0;
          fs_nxt    = 1'b1;
          state_nxt = HAS_BLANK ? BLANK : SHOW;
          cnt_nxt   = HAS_BLANK ? BLANK_LOAD : SHOW_LOAD;
        end
        BLANK: begin
          if (cnt == 16'd0) begin
            state_nxt = SHOW;
            cnt_nxt   = SHOW_LOAD;
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
        SHOW: begin
          if (cnt == 16'd0) begin
            idx_nxt   = digit_idx + 2'd1;
            state_nxt = HAS_BLANK ? BLANK : SHOW;
            cnt_nxt   = HAS_BLANK ? BLANK_LOAD : SHOW_LOAD;
            // Frame boundary: take a fresh snapshot on the wrap back to digit 0.
            if (digit_idx == 2'd3) begin
              snap_nxt = digits;
              dp_nxt   = dp_mask;
              fs_nxt   = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
          cnt_nxt   = 16'd0;
        end
      endcase
    end
    // Outputs are registered from next-state values so they change on the entering edge.
    if (state_nxt == SHOW) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = {~dp_nxt[idx_nxt], glyph(snap_nxt, idx_nxt)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      snap        <= 16'd0;
      dp_snap     <= 4'd0;
      digit_idx   <= 2'd0;
      frame_start <= 1'b0;
      seg         <= 8'hFF;
      an          <= 4'hF;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      snap        <= snap_nxt;
      dp_snap     <= dp_nxt;
      digit_idx   <= idx_nxt;
      frame_start <= fs_nxt;
      seg         <= seg_nxt;
      an          <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
// Self-checking bench for seg_scan_driver: one instance with a blanking gap,
// one without, both compared against a frame/slot arithmetic model.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;
  logic [1:0]  idx_a, idx_b;
  logic        fs_a, fs_b;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

  seg_scan_driver #(.SHOW_CYC(3), .BLANK_CYC(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_mask(dp_mask),
    .seg(seg_a), .an(an_a), .digit_idx(idx_a), .frame_start(fs_a));

  seg_scan_driver #(.SHOW_CYC(3), .BLANK_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_mask(dp_mask),
    .seg(seg_b), .an(an_b), .digit_idx(idx_b), .frame_start(fs_b));

  always #5 clk = ~clk;

  // Reference: cycles since the scan started, plus the snapshot taken at each frame start.
  bit          act_a = 0, act_b = 0;
  int          p_a = 0, p_b = 0;
  logic [15:0] sn_a = 0, sn_b = 0;
  logic [3:0]  dm_a = 0, dm_b = 0;

  always @(posedge clk) begin
    if (rst || !en) begin
      act_a = 0; act_b = 0;
      if (rst) begin sn_a = 0; sn_b = 0; dm_a = 0; dm_b = 0; end
    end else begin
      if (!act_a) begin act_a = 1; p_a = 0; end else p_a++;
      if (!act_b) begin act_b = 1; p_b = 0; end else p_b++;
      if (p_a % 16 == 0) begin sn_a = digits; dm_a = dp_mask; end
      if (p_b % 12 == 0) begin sn_b = digits; dm_b = dp_mask; end
    end
  end

  function automatic logic [14:0] model_out(input bit act, input int p, input int bc,
                                            input logic [15:0] sn, input logic [3:0] dm);
    int slot, f, s;
    logic [3:0] d, a;
    logic [7:0] sg;
    if (!act) return {8'hFF, 4'hF, 2'd0, 1'b0};
    slot = 3 + bc;
    f = p % (4 * slot);
    s = f / slot;
    d = 4'((sn >> (4 * s)) & 16'hF);
    if (f % slot < bc) begin
      sg = 8'hFF; a = 4'hF;
    end else begin
      a = ~(4'(1) << s);
      sg = GLYPH[d];
      sg[7] = ~dm[2'(s)];
`ifdef LEADING_ZERO_BLANK_EN
      if (s > 0 && (sn >> (4 * s)) == 16'd0) sg[6:0] = 7'h7F;
`endif
    end
    return {sg, a, 2'(s), (f == 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; digits = 16'($urandom); dp_mask = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({seg_a, an_a, idx_a, fs_a} !== {8'hFF, 4'hF, 2'd0, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold got=%h want=%h", {seg_a, an_a, idx_a, fs_a}, {8'hFF, 4'hF, 2'd0, 1'b0});
      end
    end
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({seg_a, an_a, idx_a, fs_a, seg_b, an_b, idx_b, fs_b} !== {2{8'hFF, 4'hF, 2'd0, 1'b0}}) begin
        failures++;
        $display("FAIL idle_dark cyc=%0d got=%h/%h want=ff/f/0/0", i,
                 {seg_a, an_a, idx_a, fs_a}, {seg_b, an_b, idx_b, fs_b});
      end
    end
  endtask

  task automatic test_scan();
    int last = -1, lit = 0;
    logic [7:0] want;
    digits = 16'h1234; dp_mask = 4'h0; en = 1;
    for (int i = 0; i < 49; i++) begin
      step();
      checks++;
      if ({seg_a, an_a, idx_a, fs_a} !== model_out(act_a, p_a, 1, sn_a, dm_a)) begin
        failures++;
        $display("FAIL scan_model cyc=%0d got=%h want=%h", i, {seg_a, an_a, idx_a, fs_a},
                 model_out(act_a, p_a, 1, sn_a, dm_a));
      end
      if (fs_a) begin
        if (last >= 0) begin
          checks++;
          if (i - last != 16 || lit != 12) begin
            failures++;
            $display("FAIL scan_frame period=%0d lit=%0d want 16/12", i - last, lit);
          end
        end
        last = i; lit = 0;
      end
      if (an_a != 4'hF) lit++;
      case (an_a)
        4'hE: want = 8'h99;
        4'hD: want = 8'hB0;
        4'hB: want = 8'hA4;
        4'h7: want = 8'hF9;
        default: want = 8'hFF;
      endcase
      checks++;
      if (seg_a !== want) begin
        failures++;
        $display("FAIL scan_digit an=%h seg=%h want=%h", an_a, seg_a, want);
      end
    end
    checks++;
    if (last != 48) begin
      failures++;
      $display("FAIL scan_last_frame got=%0d want=48", last);
    end
  endtask

  task automatic test_snapshot();
    int n = 0;
    bit hit = 0;
    logic [7:0] want;
    while (idx_a != 2'd1 && n < 20) begin step(); n++; end
    checks++;
    if (idx_a != 2'd1) begin failures++; $display("FAIL snap_wait idx=%0d want=1", idx_a); end
    digits = 16'h5678;
    n = 0;
    while (!fs_a && n < 20) begin
      step(); n++;
      case (an_a)
        4'hD: want = 8'hB0;
        4'hB: want = 8'hA4;
        4'h7: want = 8'hF9;
        default: want = seg_a;
      endcase
      if (!fs_a && an_a != 4'hE && an_a != 4'hF) begin
        checks++;
        if (seg_a !== want) begin
          failures++;
          $display("FAIL snap_hold an=%h seg=%h want=%h", an_a, seg_a, want);
        end
      end
    end
    checks++;
    if (!fs_a) begin failures++; $display("FAIL snap_frame_wait fs=%0b want=1", fs_a); end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) step();
      checks++;
      if ({seg_a, an_a, idx_a, fs_a} !== model_out(act_a, p_a, 1, sn_a, dm_a)) begin
        failures++;
        $display("FAIL snap_model got=%h want=%h", {seg_a, an_a, idx_a, fs_a},
                 model_out(act_a, p_a, 1, sn_a, dm_a));
      end
    end
    hit = (an_a == 4'hE && seg_a == 8'h80);
    checks++;
    if (!hit) begin failures++; $display("FAIL snap_new an=%h seg=%h want e/80", an_a, seg_a); end
  endtask

  task automatic test_dots();
    bit seen = 0;
    logic [7:0] want;
    digits = 16'hFA0B; dp_mask = 4'b0101;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if ({seg_a, an_a, idx_a, fs_a} !== model_out(act_a, p_a, 1, sn_a, dm_a)) begin
        failures++;
        $display("FAIL dots_model cyc=%0d got=%h want=%h", i, {seg_a, an_a, idx_a, fs_a},
                 model_out(act_a, p_a, 1, sn_a, dm_a));
      end
      if (fs_a) seen = 1;
      if (seen) begin
        case (an_a)
          4'hE: want = 8'h03;
          4'hD: want = 8'hC0;
          4'hB: want = 8'h08;
          4'h7: want = 8'h8E;
          default: want = 8'hFF;
        endcase
        checks++;
        if (seg_a !== want) begin
          failures++;
          $display("FAIL dots_digit an=%h seg=%h want=%h", an_a, seg_a, want);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    int n = 0;
    while (!(idx_a == 2'd2 && an_a == 4'hB) && n < 20) begin step(); n++; end
    checks++;
    if (an_a != 4'hB) begin failures++; $display("FAIL drop_wait an=%h want=b", an_a); end
    en = 0;
    step();
    checks++;
    if ({seg_a, an_a, idx_a, fs_a} !== {8'hFF, 4'hF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL drop_dark got=%h want=%h", {seg_a, an_a, idx_a, fs_a}, {8'hFF, 4'hF, 2'd0, 1'b0});
    end
    step(); step();
    en = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({seg_a, an_a, idx_a, fs_a} !== model_out(act_a, p_a, 1, sn_a, dm_a)) begin
        failures++;
        $display("FAIL restart_model cyc=%0d got=%h want=%h", i, {seg_a, an_a, idx_a, fs_a},
                 model_out(act_a, p_a, 1, sn_a, dm_a));
      end
      if (i == 0) begin
        checks++;
        if ({fs_a, idx_a, an_a} !== {1'b1, 2'd0, 4'hF}) begin
          failures++;
          $display("FAIL restart_start fs/idx/an=%b/%0d/%h want 1/0/f", fs_a, idx_a, an_a);
        end
      end
    end
  endtask

  task automatic test_blank0();
    bit seen = 0;
    logic [7:0] want;
    digits = 16'h0070; dp_mask = 4'h0;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if ({seg_b, an_b, idx_b, fs_b} !== model_out(act_b, p_b, 0, sn_b, dm_b)) begin
        failures++;
        $display("FAIL nob_model cyc=%0d got=%h want=%h", i, {seg_b, an_b, idx_b, fs_b},
                 model_out(act_b, p_b, 0, sn_b, dm_b));
      end
      checks++;
      if (an_b == 4'hF) begin failures++; $display("FAIL nob_gap an=%h want not f", an_b); end
      if (fs_b) seen = 1;
      if (seen) begin
        case (an_b)
          4'hE: want = 8'hC0;
          4'hD: want = 8'hF8;
`ifdef LEADING_ZERO_BLANK_EN
          default: want = 8'hFF;
`else
          default: want = 8'hC0;
`endif
        endcase
        checks++;
        if (seg_b !== want) begin
          failures++;
          $display("FAIL nob_digit an=%h seg=%h want=%h", an_b, seg_b, want);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_dots();
    test_en_drop();
    test_blank0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
